rf_write_sched: RTL and testbench

Write-port scheduler and hazard scoreboard for the integer register file `RegFile`. It arbitrates two writeback requesters onto the file's single write port: requester 0 is the ALU, requester 1 is the load unit. Arbitration is round-robin with a valid/ready handshake, and the write port is driven from registers. An optional per-register busy scoreboard reports pending writes to the issue stage for both read addresses.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/rf_write_sched.sv | 118 +++++++++++
 tb/tb_rf_write_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write scheduler.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    typedef enum logic {
        GRANT_ALU  = 1'b0,
        GRANT_LOAD = 1'b1
    } rf_grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: claim sets, completed write clears,
// flush clears everything; two combinational read ports.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              clear_valid,
    input  logic [ADDR_W-1:0] clear_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    output logic              src1_busy,
    output logic              src2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            // Claim is applied after clear so a same-cycle claim wins.
            if (clear_valid) busy_d[clear_addr] = 1'b0;
            if (claim_valid) busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign src1_busy = busy_q[src1_addr];
    assign src2_busy = busy_q[src2_addr];

endmodule

// File: rtl/rf_write_sched.sv
// Round-robin arbiter of ALU/load writebacks onto the RegFile write port.
// Define RF_SCOREBOARD_EN to include the pending-write scoreboard.
module rf_write_sched
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic [ADDR_W-1:0] dest_addr,
    output logic [DATA_W-1:0] dest_data,
    output logic              write_enable
);

    // Handshake: a request transfers in any cycle where wbN_valid && wbN_ready.

    rf_grant_e         last_grant_q, last_grant_d;
    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
    logic [DATA_W-1:0] dest_data_q, dest_data_d;

    logic              grant0;
    logic              grant1;
    logic              handshake;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (wb0_valid && wb1_valid) begin
            if (last_grant_q == GRANT_LOAD) grant0 = 1'b1;
            else                            grant1 = 1'b1;
        end else begin
            grant0 = wb0_valid;
            grant1 = wb1_valid;
        end

        handshake = grant0 | grant1;
        sel_addr  = grant1 ? wb1_addr : wb0_addr;
        sel_data  = grant1 ? wb1_data : wb0_data;

        last_grant_d   = last_grant_q;
        write_enable_d = 1'b0;
        dest_addr_d    = dest_addr_q;
        dest_data_d    = dest_data_q;
        if (handshake) begin
            last_grant_d   = grant1 ? GRANT_LOAD : GRANT_ALU;
            // x0 is accepted but never written.
            write_enable_d = (sel_addr != '0);
            dest_addr_d    = sel_addr;
            dest_data_d    = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q   <= GRANT_LOAD;
            write_enable_q <= 1'b0;
            dest_addr_q    <= '0;
            dest_data_q    <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            write_enable_q <= write_enable_d;
            dest_addr_q    <= dest_addr_d;
            dest_data_q    <= dest_data_d;
        end
    end

    assign wb0_ready    = grant0;
    assign wb1_ready    = grant1;
    assign write_enable = write_enable_q;
    assign dest_addr    = dest_addr_q;
    assign dest_data    = dest_data_q;

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .clear_valid (write_enable_q),
        .clear_addr  (dest_addr_q),
        .flush       (flush),
        .src1_addr   (src1_addr),
        .src2_addr   (src2_addr),
        .src1_busy   (src1_busy),
        .src2_busy   (src2_busy)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{claim_valid, claim_addr, flush, src1_addr, src2_addr,
                                NUM_REGS[0]};
    assign src1_busy = 1'b0;
    assign src2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed and randomized bench for rf_write_sched against a cycle-level
// model of the arbitration, write-port and pending-register rules.
module tb_rf_write_sched;
    import rf_pkg::*;

`ifdef RF_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        claim_valid, flush;
    logic [4:0]  claim_addr, src1_addr, src2_addr;
    logic        src1_busy, src2_busy;
    logic [4:0]  dest_addr;
    logic [31:0] dest_data;
    logic        write_enable;

    always #5 clk = ~clk;

    rf_write_sched dut (
        .clk          (clk),
        .rst          (rst),
        .wb0_valid    (wb0_valid),
        .wb0_addr     (wb0_addr),
        .wb0_data     (wb0_data),
        .wb0_ready    (wb0_ready),
        .wb1_valid    (wb1_valid),
        .wb1_addr     (wb1_addr),
        .wb1_data     (wb1_data),
        .wb1_ready    (wb1_ready),
        .claim_valid  (claim_valid),
        .claim_addr   (claim_addr),
        .flush        (flush),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .src1_busy    (src1_busy),
        .src2_busy    (src2_busy),
        .dest_addr    (dest_addr),
        .dest_data    (dest_data),
        .write_enable (write_enable)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: who was granted last, expected port values, pending set.
    bit          m_last_load;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_known;
    bit [31:0]   m_busy;
    bit          p_g0, p_g1, p_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy_exp(input logic [4:0] a);
        return SB_EN ? m_busy[a] : 1'b0;
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        bit          g0, g1;
        logic [4:0]  a;
        logic [31:0] d;
        bit [31:0]   n_busy;
        #1;
        if (wb0_valid && wb1_valid) begin
            g0 = m_last_load;
            g1 = !m_last_load;
        end else begin
            g0 = wb0_valid;
            g1 = wb1_valid;
        end
        chk("wb0_ready", wb0_ready, g0);
        chk("wb1_ready", wb1_ready, g1);
        chk("src1_busy", src1_busy, busy_exp(src1_addr));
        chk("src2_busy", src2_busy, busy_exp(src2_addr));

        a = g1 ? wb1_addr : wb0_addr;
        d = g1 ? wb1_data : wb0_data;
        n_busy = m_busy;
        if (flush) begin
            n_busy = '0;
        end else begin
            if (m_we) n_busy[m_addr] = 1'b0;
            if (claim_valid && claim_addr != 0) n_busy[claim_addr] = 1'b1;
        end
        p_g0  = g0;
        p_g1  = g1;
        p_rst = rst;
        if (rst) begin
            m_last_load = 1'b1;
            m_we        = 1'b0;
            m_addr      = '0;
            m_data      = '0;
            m_known     = 1'b1;
            m_busy      = '0;
        end else begin
            m_busy = n_busy;
            if (g0 || g1) begin
                m_last_load = g1;
                m_we        = (a != 0);
                m_addr      = a;
                m_data      = d;
                m_known     = (a != 0);
            end else begin
                m_we = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk("write_enable", write_enable, m_we);
        if (m_known) begin
            chk("dest_addr", dest_addr, m_addr);
            chk("dest_data", dest_data, m_data);
        end
    endtask

    task automatic idle_inputs();
        wb0_valid   = 1'b0;
        wb1_valid   = 1'b0;
        claim_valid = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        logic [4:0] alt_seq [4];
        alt_seq = '{5'd1, 5'd2, 5'd1, 5'd2};
        rst = 1'b1;
        wb0_addr = '0; wb1_addr = '0; wb0_data = '0; wb1_data = '0;
        claim_addr = '0; src1_addr = '0; src2_addr = '0;
        idle_inputs();
        m_last_load = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0;
        m_known = 1'b0; m_busy = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("reset_we", write_enable, 1'b0);
        chk("reset_dest_addr", dest_addr, 5'd0);
        chk("reset_dest_data", dest_data, 32'd0);
        rst = 1'b0;

        // Single ALU write.
        wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
        tick();
        chk("single_we", write_enable, 1'b1);
        chk("single_addr", dest_addr, 5'd5);
        chk("single_data", dest_data, 32'hDEADBEEF);
        wb0_valid = 1'b0;
        tick();
        chk("single_we_drop", write_enable, 1'b0);

        // Continuous contention from a fresh reset alternates starting with wb0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1111_0001;
        wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_dest_addr", dest_addr, alt_seq[i]);
        end
        idle_inputs();
        tick();

        // Load write to x0 is accepted but never written.
        wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h12345678;
        tick();
        chk("x0_we", write_enable, 1'b0);
        idle_inputs();
        tick();

        // Claim r7, write it two cycles later.
        src1_addr = 5'd7;
        claim_valid = 1'b1; claim_addr = 5'd7;
        tick();
        claim_valid = 1'b0;
        tick();
        wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = $urandom;
        tick();
        wb0_valid = 1'b0;
        tick();
        tick();
        chk("r7_cleared", src1_busy, 1'b0);

        // Claim r9 in the same cycle its write completes.
        src2_addr = 5'd9;
        wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = $urandom;
        tick();
        wb0_valid = 1'b0;
        claim_valid = 1'b1; claim_addr = 5'd9;
        tick();
        claim_valid = 1'b0;
        tick();
        chk("r9_claim_wins", src2_busy, SB_EN);

        // Flush clears pending r3 and r4.
        src1_addr = 5'd3; src2_addr = 5'd4;
        claim_valid = 1'b1; claim_addr = 5'd3;
        tick();
        claim_addr = 5'd4;
        tick();
        claim_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        // Reset during contention, then wb0 wins first.
        wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = $urandom;
        wb1_valid = 1'b1; wb1_addr = 5'd11; wb1_data = $urandom;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_first", dest_addr, 5'd10);
        idle_inputs();
        tick();

        // Randomized traffic; requesters hold until a non-reset handshake.
        p_g0 = 1'b1; p_g1 = 1'b1; p_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!wb0_valid || (p_g0 && !p_rst)) begin
                wb0_valid = ($urandom_range(0, 3) != 0);
                wb0_addr  = 5'($urandom_range(0, 7));
                wb0_data  = $urandom;
            end
            if (!wb1_valid || (p_g1 && !p_rst)) begin
                wb1_valid = ($urandom_range(0, 2) != 0);
                wb1_addr  = 5'($urandom_range(0, 7));
                wb1_data  = $urandom;
            end
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_addr  = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 24) == 0);
            rst         = ($urandom_range(0, 49) == 0);
            src1_addr   = 5'($urandom_range(0, 7));
            src2_addr   = 5'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
